// File: rtl/leaf_out_packetizer.sv
// Output side of a parametrised leaf shell. Round-robin arbitration of user output
// streams into BFT packets, gated by per-port credits that track remote buffer space.
module leaf_out_packetizer #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int CREDIT_INIT   = 64,
    parameter int CREDIT_BITS   = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]               vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]               ack_interface2user,
    input  logic                                   cfg_we,
    input  logic [NUM_PORT_BITS-1:0]               cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest,
    input  logic                                   credit_vld,
    input  logic [NUM_PORT_BITS-1:0]               credit_port,
    input  logic [CREDIT_BITS-1:0]                 credit_cnt,
    input  logic                                   resend,
    input  logic                                   bft_ready,
    output logic [PACKET_BITS-1:0]                 dout_leaf_interface2bft
);

    localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int PTR_BITS  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam logic [PTR_BITS:0]      PTR_LIMIT    = (PTR_BITS+1)'(NUM_OUT_PORTS);
    localparam logic [CREDIT_BITS-1:0] CREDIT_RESET = CREDIT_BITS'(CREDIT_INIT);
    localparam logic [CREDIT_BITS:0]   CREDIT_MAX   = {1'b0, {CREDIT_BITS{1'b1}}};

    logic [PACKET_BITS-1:0]   out_q;
    logic [PTR_BITS-1:0]      ptr_q;
    logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_q    [NUM_OUT_PORTS];
    logic [DEST_BITS-1:0]     dest_q   [NUM_OUT_PORTS];
    logic [PAYLOAD_BITS-1:0]  payload  [NUM_OUT_PORTS];

    logic                     out_valid;
    logic                     drain;
    logic                     can_load;
    logic [NUM_OUT_PORTS-1:0] elig;
    logic                     win;
    logic [PTR_BITS-1:0]      win_idx;
    logic [PTR_BITS-1:0]      ptr_next;
    logic [PTR_BITS:0]        scan;
    logic [PTR_BITS:0]        ptr_inc;
    logic [CREDIT_BITS:0]     credit_sum;
    logic [PACKET_BITS-1:0]   packet;

    // The held packet only leaves while resend is low, so a resend never loses it.
    assign out_valid = out_q[PACKET_BITS-1];
    assign drain     = out_valid && bft_ready && !resend;
    assign can_load  = reset && !resend && (!out_valid || bft_ready);

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            elig[i]    = can_load && vld_user2interface[i] && (credit_q[i] != '0);
            payload[i] = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            scan = {1'b0, ptr_q} + (PTR_BITS+1)'(k);
            if (scan >= PTR_LIMIT) begin
                scan = scan - PTR_LIMIT;
            end
            if (!win && elig[scan[PTR_BITS-1:0]]) begin
                win     = 1'b1;
                win_idx = scan[PTR_BITS-1:0];
            end
        end
    end

    always_comb begin
        ptr_inc  = {1'b0, win_idx} + (PTR_BITS+1)'(1);
        ptr_next = (ptr_inc >= PTR_LIMIT) ? '0 : ptr_inc[PTR_BITS-1:0];
    end

    always_comb begin
        ack_interface2user = '0;
        if (win) begin
            ack_interface2user[win_idx] = 1'b1;
        end
    end

    assign packet = {1'b1, dest_q[win_idx], seq_q[win_idx], payload[win_idx]};

    // Out-of-range credit_port never matches a port index, so it is dropped for free.
    always_comb begin
        credit_sum = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_sum = {1'b0, credit_q[i]};
            if (credit_vld && credit_port == NUM_PORT_BITS'(i)) begin
                credit_sum = credit_sum + {1'b0, credit_cnt};
            end
            if (win && win_idx == PTR_BITS'(i)) begin
                credit_sum = credit_sum - (CREDIT_BITS+1)'(1);
            end
            credit_d[i] = (credit_sum > CREDIT_MAX) ? {CREDIT_BITS{1'b1}}
                                                    : credit_sum[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            ptr_q <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= CREDIT_RESET;
                seq_q[i]    <= '0;
                dest_q[i]   <= '0;
            end
        end else begin
            if (win) begin
                out_q          <= packet;
                ptr_q          <= ptr_next;
                seq_q[win_idx] <= seq_q[win_idx] + NUM_ADDR_BITS'(1);
            end else if (drain) begin
                out_q <= '0;
            end
            // Destination writes land after this cycle's packet has been built.
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= credit_d[i];
                if (cfg_we && cfg_port == NUM_PORT_BITS'(i)) begin
                    dest_q[i] <= cfg_dest;
                end
            end
        end
    end

    assign dout_leaf_interface2bft = resend ? '0 : out_q;

endmodule
